// File: rtl/key_schedule_pkg.sv
// Shared types and constants for the round-key generator.
package key_schedule_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2,
    DONE = 2'd3
  } ks_state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/key_round_alu.sv
// Add/subtract unit producing one raw round key (mod 2^KEY_W).
import key_schedule_pkg::*;

module key_round_alu #(
  parameter int KEY_W = 64
) (
  input  logic [KEY_W-1:0] a,
  input  logic [KEY_W-1:0] b,
  input  logic             op,
  output logic [KEY_W-1:0] y
);

  assign y = (op == OP_SUB) ? (a - b) : (a + b);

endmodule

// File: rtl/key_schedule.sv
// Sequential round-key generator: one key per valid/ready handshake.
// Optional build macro KEYSCHED_RCON_EN XORs the round index into each key.
import key_schedule_pkg::*;

module key_schedule #(
  parameter int KEY_W  = 64,
  parameter int ROUNDS = 8,
  parameter int RIDX_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [KEY_W-1:0]  key,
  output logic              busy,
  output logic              round_valid,
  input  logic              round_ready,
  output logic [KEY_W-1:0]  round_key,
  output logic [RIDX_W-1:0] round_idx,
  output logic              done
);

  localparam int H = KEY_W / 2;

  ks_state_t         state, state_nx;
  logic [KEY_W-1:0]  l_q, r_q, l_nx, r_nx;
  logic [KEY_W-1:0]  alu_a, alu_b, alu_y, key_nx;
  logic              alu_op;
  logic [RIDX_W-1:0] idx_nx;
  logic              hs, last;

  assign hs   = round_valid && round_ready;
  assign last = (round_idx == RIDX_W'(ROUNDS - 1));

  key_round_alu #(.KEY_W(KEY_W)) u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .op (alu_op),
    .y  (alu_y)
  );

  // The ALU always sees the operands of the key being registered next, so
  // after an odd round it works on the freshly rotated L/R.
  always_comb begin
    state_nx = state;
    l_nx     = l_q;
    r_nx     = r_q;
    idx_nx   = round_idx;
    alu_op   = OP_ADD;
    case (state)
      IDLE: if (start) begin
        state_nx = LOAD;
        l_nx     = {{H{key[KEY_W-1]}}, key[KEY_W-1:H]};
        r_nx     = {{H{key[H-1]}}, key[H-1:0]};
      end
      LOAD: begin
        state_nx = EMIT;
        idx_nx   = '0;
      end
      EMIT: if (hs) begin
        if (round_idx[0]) begin
          l_nx = {l_q[KEY_W-2:0], l_q[KEY_W-1]};
          r_nx = {r_q[0], r_q[KEY_W-1:1]};
        end
        if (last) state_nx = DONE;
        else begin
          idx_nx = round_idx + RIDX_W'(1);
          alu_op = round_idx[0] ? OP_ADD : OP_SUB;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    alu_a = l_nx;
    alu_b = r_nx;
  end

`ifdef KEYSCHED_RCON_EN
  assign key_nx = alu_y ^ KEY_W'(idx_nx);
`else
  assign key_nx = alu_y;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      l_q         <= '0;
      r_q         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      round_valid <= 1'b0;
      round_key   <= '0;
      round_idx   <= '0;
    end else begin
      state <= state_nx;
      l_q   <= l_nx;
      r_q   <= r_nx;
      // busy covers the DONE cycle so it drops together with the done pulse
      busy  <= (state_nx != IDLE) || (state == DONE);
      done  <= (state == DONE);
      if ((state == LOAD) || ((state == EMIT) && hs && !last)) begin
        round_valid <= 1'b1;
        round_key   <= key_nx;
        round_idx   <= idx_nx;
      end else if ((state == EMIT) && hs) begin
        round_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_key_schedule.sv
// Directed scoreboard bench for key_schedule (KEY_W=64, ROUNDS=4).
module tb_key_schedule;

  localparam int KW = 64;
  localparam int RN = 4;
  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [KW-1:0] key = '0;
  logic          round_ready = 1'b1;
  logic          busy, round_valid, done;
  logic [KW-1:0] round_key;
  logic [RW-1:0] round_idx;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;
  int done_cnt = 0;
  int key_cnt  = 0;

  logic [KW-1:0] sb_key[$];
  logic [RW-1:0] sb_idx[$];

  key_schedule #(.KEY_W(KW), .ROUNDS(RN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .key         (key),
    .busy        (busy),
    .round_valid (round_valid),
    .round_ready (round_ready),
    .round_key   (round_key),
    .round_idx   (round_idx),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: rotation count before round r is r/2, odd rounds subtract.
  function automatic logic [63:0] model(input logic [63:0] k, input int r);
    logic [63:0] l, rr, v;
    l  = {{32{k[63]}}, k[63:32]};
    rr = {{32{k[31]}}, k[31:0]};
    for (int i = 0; i < r / 2; i++) begin
      l  = {l[62:0], l[63]};
      rr = {rr[0], rr[63:1]};
    end
    v = r[0] ? (l - rr) : (l + rr);
`ifdef KEYSCHED_RCON_EN
    v = v ^ 64'(r);
`endif
    return v;
  endfunction

  task automatic push_model(input logic [63:0] k);
    for (int r = 0; r < RN; r++) begin
      sb_key.push_back(model(k, r));
      sb_idx.push_back(RW'(r));
    end
  endtask

  task automatic do_start(input logic [63:0] k);
    start = 1'b1;
    key   = k;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns number of edges until done is seen; marks failure on timeout.
  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (done) break;
    end
    chk({tag, "_done"}, done, 1'b1);
    @(posedge clk); #1;
    chk({tag, "_idle_busy"}, busy, 1'b0);
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_sb_empty"}, sb_key.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && done) done_cnt++;
    if (rst_n && round_valid && round_ready) begin
      key_cnt++;
      if (sb_key.size() == 0) begin
        total++;
        fail_cnt++;
        $error("FAIL extra_key: got %h expected none", round_key);
      end else begin
        chk("key", round_key, sb_key.pop_front());
        chk("idx", 64'(round_idx), 64'(sb_idx.pop_front()));
      end
    end
  end

  initial begin
    int cyc, d0, k0;
    logic [63:0] kb;
    kb = 64'h0000_0005_0000_0003;

    // reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", round_valid, 1'b0);
    chk("rst_key", round_key, 64'h0);
    chk("rst_idx", 64'(round_idx), 64'h0);
    chk("rst_done", done, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic: fixed expected values and latency
`ifdef KEYSCHED_RCON_EN
    sb_key.push_back(64'h8); sb_key.push_back(64'h3);
    sb_key.push_back(64'h8000_0000_0000_0009); sb_key.push_back(64'h8000_0000_0000_000A);
`else
    sb_key.push_back(64'h8); sb_key.push_back(64'h2);
    sb_key.push_back(64'h8000_0000_0000_000B); sb_key.push_back(64'h8000_0000_0000_0009);
`endif
    for (int r = 0; r < RN; r++) sb_idx.push_back(RW'(r));
    do_start(kb);
    chk("lat_busy", busy, 1'b1);
    chk("lat_valid0", round_valid, 1'b0);
    @(posedge clk); #1;
    chk("lat_valid1", round_valid, 1'b1);
    wait_done("basic", cyc);
    chk("basic_done_cycle", 64'(cyc + 1), 64'd6);

    // sign extension of upper half
    push_model(64'hFFFF_FFFF_0000_0001);
    do_start(64'hFFFF_FFFF_0000_0001);
    wait_done("sext", cyc);

    // backpressure during round 1
    push_model(kb);
    do_start(kb);
    @(posedge clk); #1;
    @(posedge clk); #1;
    round_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_key", round_key, model(kb, 1));
      chk("bp_idx", 64'(round_idx), 64'd1);
      chk("bp_valid", round_valid, 1'b1);
    end
    round_ready = 1'b1;
    wait_done("bp", cyc);

    // reset mid-schedule while round 2 is presented
    push_model(64'h1234_5678_9ABC_DEF0);
    do_start(64'h1234_5678_9ABC_DEF0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_idx2", 64'(round_idx), 64'd2);
    d0 = done_cnt;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mr_busy", busy, 1'b0);
    chk("mr_valid", round_valid, 1'b0);
    chk("mr_key", round_key, 64'h0);
    chk("mr_idx", 64'(round_idx), 64'h0);
    sb_key.delete();
    sb_idx.delete();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    chk("mr_no_done", done_cnt, d0);
    push_model(64'h1234_5678_9ABC_DEF0);
    do_start(64'h1234_5678_9ABC_DEF0);
    wait_done("mr_restart", cyc);

    // start pulsed while busy is ignored
    k0 = key_cnt;
    push_model(64'h8000_0001_7FFF_FFFF);
    do_start(64'h8000_0001_7FFF_FFFF);
    @(posedge clk); #1;
    start = 1'b1;
    key   = 64'hDEAD_BEEF_0BAD_F00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("sb", cyc);
    chk("sb_key_count", key_cnt - k0, RN);
    push_model(64'h0000_0007_FFFF_FFFE);
    do_start(64'h0000_0007_FFFF_FFFE);
    wait_done("sb_new", cyc);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
